gpio_pad_cfg: RTL

Per-pad configuration and data-steering stage sitting directly upstream of the user-project pad ring. It holds one pad's 13-bit mode word, loaded over a daisy-chained serial bus from housekeeping. It drives the per-pad control bundle: mode, input disable, trip select, slew, hold, analog enables and drive mode. It also steers the pad's data and output-enable between the management SoC and the user project. One instance per `MPRJ_IO_PADS` bit; `serial_data_out` of pad n feeds `serial_data_in` of pad n+1.

---
 rtl/gpio_pad_cfg.sv | 94 +++++++++
 1 files changed

// File: rtl/gpio_pad_cfg.sv
// Per-pad configuration holder and data steering for one user-project GPIO pad.
// A 13-bit serial shift chain feeds an active config word that drives the pad controls.
module gpio_pad_cfg #(
    parameter int                  CFG_BITS    = 13,
    parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h1803
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       serial_data_in,
    input  logic       serial_shift_en,
    input  logic       serial_load,
    output logic       serial_data_out,
    input  logic       mgmt_gpio_out,
    input  logic       mgmt_gpio_oeb,
    output logic       mgmt_gpio_in,
    input  logic       user_gpio_out,
    input  logic       user_gpio_oeb,
    output logic       user_gpio_in,
    input  logic       pad_gpio_in,
    output logic       pad_gpio_out,
    output logic       pad_gpio_outenb,
    output logic       pad_gpio_inenb,
    output logic       pad_gpio_ib_mode_sel,
    output logic       pad_gpio_vtrip_sel,
    output logic       pad_gpio_slow_sel,
    output logic       pad_gpio_holdover,
    output logic       pad_gpio_ana_en,
    output logic       pad_gpio_ana_sel,
    output logic       pad_gpio_ana_pol,
    output logic [2:0] pad_gpio_dm
);

    localparam int MGMT_ENA_BIT  = 0;
    localparam int OUTENB_BIT    = 1;
    localparam int HOLDOVER_BIT  = 2;
    localparam int INP_DIS_BIT   = 3;
    localparam int IB_MODE_BIT   = 4;
    localparam int ANA_EN_BIT    = 5;
    localparam int ANA_SEL_BIT   = 6;
    localparam int ANA_POL_BIT   = 7;
    localparam int SLOW_SEL_BIT  = 8;
    localparam int VTRIP_SEL_BIT = 9;
    localparam int DM_LSB        = 10;

    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic                mgmt_ena;
    logic                inp_dis;

    // Load captures the pre-shift register, so a same-cycle shift cannot leak into cfg.
    always_comb begin
        shreg_d = shreg_q;
        cfg_d   = cfg_q;
        if (serial_load) begin
            cfg_d = shreg_q;
        end
        if (serial_shift_en) begin
            shreg_d = {shreg_q[CFG_BITS-2:0], serial_data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            shreg_q <= '0;
            cfg_q   <= CFG_DEFAULT;
        end else begin
            shreg_q <= shreg_d;
            cfg_q   <= cfg_d;
        end
    end

    assign serial_data_out = shreg_q[CFG_BITS-1];

    assign mgmt_ena = cfg_q[MGMT_ENA_BIT];
    assign inp_dis  = cfg_q[INP_DIS_BIT];

    assign pad_gpio_inenb       = inp_dis;
    assign pad_gpio_ib_mode_sel = cfg_q[IB_MODE_BIT];
    assign pad_gpio_vtrip_sel   = cfg_q[VTRIP_SEL_BIT];
    assign pad_gpio_slow_sel    = cfg_q[SLOW_SEL_BIT];
    assign pad_gpio_holdover    = cfg_q[HOLDOVER_BIT];
    assign pad_gpio_ana_en      = cfg_q[ANA_EN_BIT];
    assign pad_gpio_ana_sel     = cfg_q[ANA_SEL_BIT];
    assign pad_gpio_ana_pol     = cfg_q[ANA_POL_BIT];
    assign pad_gpio_dm          = cfg_q[DM_LSB +: 3];

    // The config outenb bit can only force the pad off while management owns it.
    assign pad_gpio_out    = mgmt_ena ? mgmt_gpio_out : user_gpio_out;
    assign pad_gpio_outenb = mgmt_ena ? (cfg_q[OUTENB_BIT] | mgmt_gpio_oeb) : user_gpio_oeb;

    assign mgmt_gpio_in = pad_gpio_in & mgmt_ena & ~inp_dis;
    assign user_gpio_in = pad_gpio_in & ~mgmt_ena & ~inp_dis;

endmodule
